// File: rtl/cdr_pi_loop_filter.sv
// Second-order (proportional + integral) bang-bang CDR loop filter.
// Early/late votes are decimated, then drive a saturating frequency integrator and a wrapping phase accumulator.
module cdr_pi_loop_filter #(
    parameter int FREQ_W   = 20,
    parameter int PHASE_W  = 16,
    parameter int CODE_W   = 10,
    parameter int KP_SHIFT = 0,
    parameter int KI_SHIFT = 10,
    parameter int DECIM    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up,
    input  logic              dn,
    input  logic              en,
    input  logic              freq_hold,
    input  logic              freq_load,
    input  logic [FREQ_W-1:0] freq_load_val,
    output logic [CODE_W-1:0] code,
    output logic [FREQ_W-1:0] freq_word,
    output logic              freq_sat,
    output logic              update_strb
);

    localparam int ACC_W  = 6;
    localparam int CNT_W  = 5;
    localparam int FSUM_W = FREQ_W + 1;

    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(DECIM - 1);
    localparam logic signed [FREQ_W-1:0] F_MAX    = {1'b0, {(FREQ_W-1){1'b1}}};
    localparam logic signed [FREQ_W-1:0] F_MIN    = -F_MAX;
    localparam logic [FREQ_W-1:0]        F_MOST_NEG = {1'b1, {(FREQ_W-1){1'b0}}};

    logic signed [ACC_W-1:0]  acc_reg, acc_next;
    logic [CNT_W-1:0]         cnt_reg, cnt_next;
    logic signed [FREQ_W-1:0] freq_reg, freq_next;
    logic [PHASE_W-1:0]       phase_reg, phase_next;
    logic                     strb_reg;

    logic signed [ACC_W-1:0]  vote;
    logic signed [ACC_W-1:0]  s_val;
    logic signed [FSUM_W-1:0] f_sum;
    logic                     update;

    always_comb begin
        vote = '0;
        if (up && !dn)
            vote = ACC_W'(1);
        else if (dn && !up)
            vote = {ACC_W{1'b1}};
    end

    assign s_val  = acc_reg + vote;
    assign update = en && (cnt_reg == CNT_LAST);
    assign f_sum  = FSUM_W'(freq_reg) + FSUM_W'(s_val);

    always_comb begin
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        freq_next  = freq_reg;
        phase_next = phase_reg;

        if (en) begin
            if (update) begin
                acc_next = '0;
                cnt_next = '0;
            end else begin
                acc_next = s_val;
                cnt_next = cnt_reg + 1'b1;
            end
        end

        // A preload wins over the integrator; the most negative code is folded to -MAX.
        if (freq_load) begin
            freq_next = (freq_load_val == F_MOST_NEG) ? F_MIN : $signed(freq_load_val);
        end else if (update && !freq_hold) begin
            if (f_sum > FSUM_W'(F_MAX))
                freq_next = F_MAX;
            else if (f_sum < FSUM_W'(F_MIN))
                freq_next = F_MIN;
            else
                freq_next = f_sum[FREQ_W-1:0];
        end

        // Phase uses the pre-update frequency; truncation gives the modulo wrap.
        if (update)
            phase_next = phase_reg
                       + (PHASE_W'(s_val) <<< KP_SHIFT)
                       + PHASE_W'(freq_reg >>> KI_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg   <= '0;
            cnt_reg   <= '0;
            freq_reg  <= '0;
            phase_reg <= '0;
            strb_reg  <= 1'b0;
        end else begin
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            freq_reg  <= freq_next;
            phase_reg <= phase_next;
            strb_reg  <= update;
        end
    end

    assign code        = phase_reg[PHASE_W-1 -: CODE_W];
    assign freq_word   = freq_reg;
    assign freq_sat    = (freq_reg == F_MAX) || (freq_reg == F_MIN);
    assign update_strb = strb_reg;

endmodule

// File: tb/tb_cdr_pi_loop_filter.sv
// Bench for cdr_pi_loop_filter: two instances (DECIM=1 and DECIM=4) share stimulus and are
// compared every cycle against an arithmetic model, plus directed literal checks.
module tb_cdr_pi_loop_filter;

    localparam int MAXF = 524287;

    logic        clk = 1'b0;
    logic        rst, up, dn, en, freq_hold, freq_load;
    logic [19:0] freq_load_val;

    logic [9:0]  code1, code4;
    logic [19:0] fw1, fw4;
    logic        sat1, sat4, strb1, strb4;

    int n_vec = 0;
    int n_err = 0;

    int m_acc[2], m_cnt[2], m_freq[2], m_phase[2];
    bit m_strb[2];
    int decim[2] = '{1, 4};
    bit started = 1'b0;

    always #5 clk = ~clk;

    cdr_pi_loop_filter #(.DECIM(1)) dut1 (
        .clk(clk), .rst(rst), .up(up), .dn(dn), .en(en), .freq_hold(freq_hold),
        .freq_load(freq_load), .freq_load_val(freq_load_val),
        .code(code1), .freq_word(fw1), .freq_sat(sat1), .update_strb(strb1)
    );

    cdr_pi_loop_filter #(.DECIM(4)) dut4 (
        .clk(clk), .rst(rst), .up(up), .dn(dn), .en(en), .freq_hold(freq_hold),
        .freq_load(freq_load), .freq_load_val(freq_load_val),
        .code(code4), .freq_word(fw4), .freq_sat(sat4), .update_strb(strb4)
    );

    function automatic int clampf(input int x);
        if (x > MAXF) return MAXF;
        if (x < -MAXF) return -MAXF;
        return x;
    endfunction

    function automatic int floordiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int wrap16(input int x);
        return ((x % 65536) + 65536) % 65536;
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference model: votes summed per window of DECIM enabled cycles.
    always @(posedge clk) begin
        int v, s, nf, lv;
        bit upd;
        if (rst) started = 1'b1;
        v  = (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
        lv = int'($signed(freq_load_val));
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_acc[k] = 0; m_cnt[k] = 0; m_freq[k] = 0; m_phase[k] = 0; m_strb[k] = 1'b0;
            end else begin
                upd = 1'b0;
                s   = 0;
                if (en) begin
                    if (m_cnt[k] == decim[k] - 1) begin
                        s = m_acc[k] + v; upd = 1'b1; m_acc[k] = 0; m_cnt[k] = 0;
                    end else begin
                        m_acc[k] += v; m_cnt[k]++;
                    end
                end
                nf = m_freq[k];
                if (freq_load) nf = clampf(lv);
                else if (upd && !freq_hold) nf = clampf(m_freq[k] + s);
                if (upd) m_phase[k] = wrap16(m_phase[k] + s + floordiv(m_freq[k], 1024));
                m_freq[k] = nf;
                m_strb[k] = upd;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("code1", code1, m_phase[0] / 64);
            chk("freq1", $signed(fw1), m_freq[0]);
            chk("sat1", sat1, (m_freq[0] == MAXF || m_freq[0] == -MAXF) ? 1 : 0);
            chk("strb1", strb1, m_strb[0]);
            chk("code4", code4, m_phase[1] / 64);
            chk("freq4", $signed(fw4), m_freq[1]);
            chk("sat4", sat4, (m_freq[1] == MAXF || m_freq[1] == -MAXF) ? 1 : 0);
            chk("strb4", strb4, m_strb[1]);
        end
    end

    task automatic step(input bit u, input bit d);
        up = u;
        dn = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0);
        rst = 1'b0;
    endtask

    task automatic load(input logic [19:0] val);
        freq_load = 1'b1;
        freq_load_val = val;
        step(0, 0);
        freq_load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; up = 0; dn = 0; en = 1'b1; freq_hold = 1'b0;
        freq_load = 1'b0; freq_load_val = '0;
        #2;
        do_reset();
        chk("rst_code", code1, 0);
        chk("rst_freq", $signed(fw1), 0);
        chk("rst_strb", strb1, 0);

        // T1: three up votes
        do_reset();
        repeat (3) step(1, 0);
        chk("t1_freq", $signed(fw1), 3);
        chk("t1_strb", strb1, 1);
        chk("t1_model_phase", m_phase[0], 3);

        // T2: pure frequency drive, one phase LSB per cycle
        do_reset();
        load(20'd1024);
        repeat (64) step(0, 0);
        chk("t2_code", code1, 1);
        chk("t2_freq", $signed(fw1), 1024);
        chk("t2_model_phase", m_phase[0], 64);

        // T3: negative frequency wraps the phase downward
        do_reset();
        load(20'hFFC00);
        repeat (2) step(0, 0);
        chk("t3_code", code1, 10'h3FF);
        chk("t3_model_phase", m_phase[0], 16'hFFFE);
        do_reset();
        load(20'hFFFFF);
        repeat (3) step(0, 0);
        chk("t3_floor_phase", m_phase[0], 16'hFFFD);

        // T4: saturation at both rails
        do_reset();
        load(20'h7FFFF);
        repeat (4) step(1, 0);
        chk("t4_freq_pos", $signed(fw1), MAXF);
        chk("t4_sat_pos", sat1, 1);
        load(20'h80000);
        chk("t4_freq_negload", $signed(fw1), -MAXF);
        chk("t4_sat_neg", sat1, 1);
        repeat (2) step(0, 1);
        chk("t4_freq_neg", $signed(fw1), -MAXF);

        // T5: decimation by 4
        do_reset();
        step(1, 0); step(1, 0); step(0, 1);
        chk("t5_nostrb", strb4, 0);
        step(1, 0);
        chk("t5_strb", strb4, 1);
        chk("t5_freq", $signed(fw4), 2);
        repeat (3) step(1, 1);
        chk("t5_nostrb2", strb4, 0);
        step(1, 1);
        chk("t5_strb2", strb4, 1);
        chk("t5_freq2", $signed(fw4), 2);

        // T6: full hold, frequency hold, reset mid-window
        do_reset();
        en = 1'b0;
        repeat (10) step(1, 0);
        chk("t6_en_freq", $signed(fw1), 0);
        chk("t6_en_strb", strb1, 0);
        chk("t6_en_freq4", $signed(fw4), 0);
        en = 1'b1;
        load(20'd1024);
        freq_hold = 1'b1;
        repeat (5) step(1, 0);
        chk("t6_hold_freq", $signed(fw1), 1024);
        chk("t6_hold_model_phase", m_phase[0], 10);
        freq_hold = 1'b0;
        do_reset();
        step(1, 0); step(1, 0);
        rst = 1'b1;
        step(1, 0);
        rst = 1'b0;
        chk("t6_rst_freq4", $signed(fw4), 0);
        chk("t6_rst_strb4", strb4, 0);
        repeat (3) step(1, 0);
        chk("t6_rst_nostrb4", strb4, 0);
        step(1, 0);
        chk("t6_rst_strb4b", strb4, 1);
        chk("t6_rst_freq4b", $signed(fw4), 4);

        // Randomized traffic against the model
        repeat (3000) begin
            logic [19:0] pick;
            rst       = ($urandom_range(0, 199) == 0);
            en        = ($urandom_range(0, 7) != 0);
            freq_hold = ($urandom_range(0, 5) == 0);
            freq_load = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 3))
                0: pick = 20'($urandom);
                1: pick = 20'h7FFFF;
                2: pick = 20'h80000;
                default: pick = 20'h7FFF0;
            endcase
            freq_load_val = pick;
            step(1'($urandom), 1'($urandom));
        end
        rst = 1'b0; freq_load = 1'b0;
        step(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
